// File: rtl/scaler_pkg.sv
// ---------------------------------------------------------------------------
// scaler_pkg
// Shared definitions for the scaler result readout path: the reader FSM state
// encoding, the pixel/address widths and the per-pixel line/frame tag bundle
// that travels alongside each pixel through the output buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package scaler_pkg;

   localparam int ADDR_W  = 14;
   localparam int MAX_DIM = 63;
   localparam int PIX_W   = 8;
   localparam int CNT_W   = 12;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } state_t;

   typedef struct packed {
      logic sol;
      logic eol;
      logic eof;
   } tag_t;

endpackage

// File: rtl/rsr_obuf.sv
// ---------------------------------------------------------------------------
// rsr_obuf
// Two-entry FIFO holding returned SRAM pixels together with their tags.
// The head entry is presented combinationally; push and pop may happen in the
// same cycle, in which case the occupancy stays the same.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset (empties the FIFO)
//   push       write push_tag/push_data at the tail
//   push_tag   SOL/EOL/EOF tags of the pixel being written
//   push_data  pixel value being written
//   pop        remove the head entry (only when occ != 0)
//   occ        number of valid entries (0..2)
//   head_tag   tags of the head entry
//   head_data  pixel value of the head entry
// ---------------------------------------------------------------------------
module rsr_obuf
   import scaler_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  tag_t             push_tag,
   input  logic [PIX_W-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       occ,
   output tag_t             head_tag,
   output logic [PIX_W-1:0] head_data
);

   tag_t             tag_mem  [2];
   logic [PIX_W-1:0] data_mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             pop_ok;

   assign pop_ok    = pop && (occ != 2'd0);
   assign head_tag  = tag_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Storage, pointers and occupancy. The reader's credit logic guarantees a
   // push never lands on a full buffer without a simultaneous pop.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tag_mem[0]  <= '0;
         tag_mem[1]  <= '0;
         data_mem[0] <= '0;
         data_mem[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         occ         <= 2'd0;
      end else begin
         assert (!(push && !pop_ok && occ == 2'd2));
         if (push) begin
            tag_mem[wr_ptr]  <= push_tag;
            data_mem[wr_ptr] <= push_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop_ok})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/result_stream_reader.sv
// ---------------------------------------------------------------------------
// result_stream_reader
// Reads a finished TW x TH image back from ResultSRAM starting at BASE_ADDR
// and streams it out in raster order on a valid/ready interface carrying
// start-of-line, end-of-line and end-of-frame markers.
// Optional feature (macro READ_CHECKSUM_EN): adds CHKSUM, the modulo-2^16
// sum of all handshaken pixels of the frame.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   START         one-cycle pulse starting a frame (accepted in IDLE only)
//   TW, TH        frame width / height, latched on START accept
//   SRAM_CEN      SRAM chip enable, active-low, low on read-issue cycles
//   SRAM_A        SRAM read address
//   SRAM_Q        SRAM read data, valid the cycle after the issue cycle
//   PIX_VALID/PIX_READY/PIX_DATA  output pixel stream
//   PIX_SOL/PIX_EOL/PIX_EOF       column 0 / column TW-1 / last pixel markers
//   BUSY          frame in progress
//   DONE          one-cycle pulse after the final handshake
//   CHKSUM        (READ_CHECKSUM_EN only) pixel sum, valid from DONE
// ---------------------------------------------------------------------------
module result_stream_reader #(
   parameter int                ADDR_W     = scaler_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                OBUF_DEPTH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [5:0]        TW,
   input  logic [5:0]        TH,
   output logic              SRAM_CEN,
   output logic [ADDR_W-1:0] SRAM_A,
   input  logic [7:0]        SRAM_Q,
   output logic              PIX_VALID,
   input  logic              PIX_READY,
   output logic [7:0]        PIX_DATA,
   output logic              PIX_SOL,
   output logic              PIX_EOL,
   output logic              PIX_EOF,
   output logic              BUSY,
   output logic              DONE
`ifdef READ_CHECKSUM_EN
   ,
   output logic [15:0]       CHKSUM
`endif
);

   import scaler_pkg::*;

   localparam logic [2:0] CREDITS = 3'(OBUF_DEPTH);

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       tw_q;
   logic [5:0]       th_q;
   logic [5:0]       col;
   logic [5:0]       row;
   logic [CNT_W-1:0] rd_cnt;
   logic             inflight;
   tag_t             inflight_tag;
   tag_t             issue_tag;
   tag_t             head_tag;
   logic [1:0]       occ;
   logic [2:0]       credit_use;
   logic             start_ok;
   logic             pop;
   logic             issue;
   logic             last_pix;

   assign start_ok  = (state == IDLE) && START;
   assign PIX_VALID = (occ != 2'd0);
   assign pop       = PIX_VALID && PIX_READY;
   assign last_pix  = (col == tw_q - 6'd1) && (row == th_q - 6'd1);

   // A pop implies occ >= 1, so this never underflows. It is the buffer
   // occupancy one edge from now if nothing new is issued this cycle.
   assign credit_use = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue      = (state == ISSUE) && (credit_use < CREDITS);

   assign issue_tag.sol = (col == 6'd0);
   assign issue_tag.eol = (col == tw_q - 6'd1);
   assign issue_tag.eof = last_pix;

   assign SRAM_CEN = ~issue;
   assign SRAM_A   = issue ? (BASE_ADDR + ADDR_W'(rd_cnt)) : '0;
   assign BUSY     = (state == ISSUE) || (state == DRAIN);
   assign DONE     = (state == FIN);
   assign PIX_SOL  = head_tag.sol;
   assign PIX_EOL  = head_tag.eol;
   assign PIX_EOF  = head_tag.eof;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. DRAIN leaves as soon as the buffer will be empty after
   // this edge, so DONE lands exactly one cycle after the EOF handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (START) begin
               state_nxt = ((TW == 6'd0) || (TH == 6'd0)) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if (issue && last_pix) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Frame geometry latch and raster issue counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tw_q   <= '0;
         th_q   <= '0;
         col    <= '0;
         row    <= '0;
         rd_cnt <= '0;
      end else if (start_ok) begin
         tw_q   <= TW;
         th_q   <= TH;
         col    <= '0;
         row    <= '0;
         rd_cnt <= '0;
      end else if (issue) begin
         rd_cnt <= rd_cnt + 1'b1;
         if (col == tw_q - 6'd1) begin
            col <= '0;
            row <= row + 6'd1;
         end else begin
            col <= col + 6'd1;
         end
      end
   end

   // Tracks the read issued last cycle so its data and tags are captured when
   // SRAM_Q becomes valid. Reset drops any read still in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         inflight     <= 1'b0;
         inflight_tag <= '0;
      end else begin
         inflight     <= issue;
         inflight_tag <= issue_tag;
      end
   end

   rsr_obuf u_obuf (
      .CLK       (CLK),
      .RST       (RST),
      .push      (inflight),
      .push_tag  (inflight_tag),
      .push_data (SRAM_Q),
      .pop       (pop),
      .occ       (occ),
      .head_tag  (head_tag),
      .head_data (PIX_DATA)
   );

`ifdef READ_CHECKSUM_EN
   // Running sum of accepted pixels; holds after DONE until the next START.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CHKSUM <= '0;
      end else if (start_ok) begin
         CHKSUM <= '0;
      end else if (pop) begin
         CHKSUM <= CHKSUM + {8'd0, PIX_DATA};
      end
   end
`endif

endmodule
